// File: rtl/id_ex_reg.sv
// id_ex_reg -- ID/EX pipeline register with load-use hazard detection.
//
// Holds one decoded instruction between the ID and EX stages. Each rising
// edge it kills the entry (flush), holds it (ex_stall), inserts a bubble
// when the ID instruction needs a load result that is still in EX
// (load-use), or captures the ID instruction.
//
// Ports:
//   clk, reset          pipeline clock; asynchronous active-low reset
//   id_*                decoded instruction presented by the ID stage
//   flush               redirect from EX; kills the ID->EX transfer
//   ex_stall            EX busy; every ex_* register holds
//   ex_*                registered instruction seen by the EX stage
//   id_stall            combinational; upstream IF/ID must hold
//   load_use_cnt        saturating count of inserted load-use bubbles
//
// CNT_MAX is the counter ceiling; it stays at 16'hFFFF in normal use.
module id_ex_reg #(
   parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [31:0] id_rd1,
   input  logic [31:0] id_rd2,
   input  logic [31:0] id_imm,
   input  logic [15:0] id_ctrl,
   input  logic        id_is_load,
   input  logic        id_reg_write,
   input  logic        flush,
   input  logic        ex_stall,
   output logic        ex_valid,
   output logic        ex_is_load,
   output logic        ex_reg_write,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_rd1,
   output logic [31:0] ex_rd2,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_rs1,
   output logic [4:0]  ex_rs2,
   output logic [4:0]  ex_rd,
   output logic [15:0] ex_ctrl,
   output logic        id_stall,
   output logic [15:0] load_use_cnt
);

   logic rs1_hit;
   logic rs2_hit;
   logic load_use;

   // A load targeting x0 never produces a value anyone waits for.
   assign rs1_hit  = id_rs1_used & (id_rs1 == ex_rd);
   assign rs2_hit  = id_rs2_used & (id_rs2 == ex_rd);
   assign load_use = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid
                     & (rs1_hit | rs2_hit);

   // A flush discards the ID instruction anyway, so a hazard against it
   // must not hold the front end.
   assign id_stall = ex_stall | (load_use & ~flush);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid     <= 1'b0;
         ex_is_load   <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_pc        <= '0;
         ex_rd1       <= '0;
         ex_rd2       <= '0;
         ex_imm       <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_ctrl      <= '0;
         load_use_cnt <= '0;
      end else if (flush) begin
         // Bubble: only the qualifying bits matter, payload is left stale.
         ex_valid     <= 1'b0;
         ex_is_load   <= 1'b0;
         ex_reg_write <= 1'b0;
      end else if (ex_stall) begin
         // Hold everything.
      end else if (load_use) begin
         ex_valid     <= 1'b0;
         ex_is_load   <= 1'b0;
         ex_reg_write <= 1'b0;
         if (load_use_cnt != CNT_MAX)
            load_use_cnt <= load_use_cnt + 16'd1;
      end else begin
         ex_valid     <= id_valid;
         // An empty slot must never load or write the register file.
         ex_is_load   <= id_is_load & id_valid;
         ex_reg_write <= id_reg_write & id_valid;
         ex_pc        <= id_pc;
         ex_rd1       <= id_rd1;
         ex_rd2       <= id_rd2;
         ex_imm       <= id_imm;
         ex_rs1       <= id_rs1;
         ex_rs2       <= id_rs2;
         ex_rd        <= id_rd;
         ex_ctrl      <= id_ctrl;
      end
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg -- self-checking bench for id_ex_reg.
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level model of the EX-stage slot kept in this file.
module tb_id_ex_reg;

   localparam logic [15:0] SAT = 16'h0020;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        id_valid = 1'b0;
   logic [31:0] id_pc = '0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0;
   logic [31:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
   logic [15:0] id_ctrl = '0;
   logic        id_is_load = 1'b0, id_reg_write = 1'b0;
   logic        flush = 1'b0, ex_stall = 1'b0;
   logic        ex_valid, ex_is_load, ex_reg_write;
   logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [15:0] ex_ctrl;
   logic        id_stall;
   logic [15:0] load_use_cnt;

   id_ex_reg #(.CNT_MAX(SAT)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .id_is_load(id_is_load), .id_reg_write(id_reg_write),
      .flush(flush), .ex_stall(ex_stall),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write),
      .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
      .id_stall(id_stall), .load_use_cnt(load_use_cnt)
   );

   always #5 clk = ~clk;

   // Model of what EX holds: an instruction record, whether its payload is
   // defined (a bubble leaves payload unspecified), and the bubble count.
   typedef struct packed {
      logic        valid, is_load, reg_write;
      logic [31:0] pc, rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [15:0] ctrl;
   } ex_t;

   ex_t         m;
   logic        known;
   logic [15:0] m_cnt;
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] held_rd2;
   logic [31:0] held_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m     = '0;
      m_cnt = '0;
      known = 1'b1;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "/ex_valid"}, 32'(ex_valid), 32'(m.valid));
      chk({tag, "/ex_is_load"}, 32'(ex_is_load), 32'(m.is_load));
      chk({tag, "/ex_reg_write"}, 32'(ex_reg_write), 32'(m.reg_write));
      chk({tag, "/load_use_cnt"}, 32'(load_use_cnt), 32'(m_cnt));
      if (known) begin
         chk({tag, "/ex_pc"}, ex_pc, m.pc);
         chk({tag, "/ex_rd1"}, ex_rd1, m.rd1);
         chk({tag, "/ex_rd2"}, ex_rd2, m.rd2);
         chk({tag, "/ex_imm"}, ex_imm, m.imm);
         chk({tag, "/ex_regs"}, {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, m.rs1, m.rs2, m.rd});
         chk({tag, "/ex_ctrl"}, 32'(ex_ctrl), 32'(m.ctrl));
      end
      $display("[%0t] %s: ex_valid=%0b ex_rd=%0d ex_pc=%h cnt=%0d id_stall=%0b",
               $time, tag, ex_valid, ex_rd, ex_pc, load_use_cnt, id_stall);
   endtask

   // Present a new ID instruction; payload fields are random.
   task automatic set_instr(input logic v, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                            input logic ld, input logic rw);
      id_valid = v;     id_rs1 = rs1;  id_rs1_used = u1;
      id_rs2 = rs2;     id_rs2_used = u2; id_rd = rd;
      id_is_load = ld;  id_reg_write = rw;
      id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom;
      id_imm = $urandom; id_ctrl = 16'($urandom);
   endtask

   // One clock: check id_stall before the edge, advance the model, check EX.
   task automatic cycle(input string tag);
      ex_t  nxt;
      logic lu;
      #1;
      lu = m.valid && m.is_load && (m.rd != 5'd0) && id_valid &&
           ((id_rs1_used && id_rs1 == m.rd) || (id_rs2_used && id_rs2 == m.rd));
      chk({tag, "/id_stall"}, 32'(id_stall), 32'(ex_stall | (lu & ~flush)));
      nxt = m;
      if (flush || (!ex_stall && lu)) begin
         nxt.valid = 1'b0; nxt.is_load = 1'b0; nxt.reg_write = 1'b0;
      end else if (!ex_stall) begin
         nxt = '{id_valid, id_is_load & id_valid, id_reg_write & id_valid,
                 id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_ctrl};
      end
      @(posedge clk);
      #1;
      if (flush || (!ex_stall && lu)) known = 1'b0;
      else if (!ex_stall) known = 1'b1;
      if (!flush && !ex_stall && lu && m_cnt < SAT) m_cnt = m_cnt + 16'd1;
      m = nxt;
      check_outputs(tag);
   endtask

   task automatic async_reset(input string tag);
      reset = 1'b0;
      #1;
      model_reset();
      check_outputs(tag);
      ex_stall = 1'b1; #1;
      chk({tag, "/id_stall_rst1"}, 32'(id_stall), 32'd1);
      ex_stall = 1'b0; #1;
      chk({tag, "/id_stall_rst0"}, 32'(id_stall), 32'd0);
      reset = 1'b1;
   endtask

   initial begin
      // Reset from time zero, checked without any clock edge.
      #1;
      async_reset("reset");
      @(posedge clk); #1;

      // Normal capture, one-cycle latency.
      set_instr(1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 1);
      id_pc = 32'h100; id_rd1 = 32'h8;
      cycle("normal");
      chk("normal/pc_const", ex_pc, 32'h100);
      chk("normal/rd1_const", ex_rd1, 32'h8);
      chk("normal/rd_const", 32'(ex_rd), 32'd3);

      // Bubble slot never loads or writes.
      set_instr(0, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
      cycle("empty_slot");

      // Load-use: lw x5 then add x6,x5,x1.
      set_instr(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);
      cycle("lw_x5");
      set_instr(1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 1);
      #1;
      chk("load_use/stall_same_cycle", 32'(id_stall), 32'd1);
      cycle("load_use_bubble");
      chk("load_use/cnt_const", 32'(load_use_cnt), 32'd1);
      cycle("load_use_capture");
      chk("load_use/rd_const", 32'(ex_rd), 32'd6);
      chk("load_use/stall_after", 32'(id_stall), 32'd0);

      // x0 producer never stalls.
      set_instr(1, 5'd4, 1, 5'd0, 0, 5'd0, 1, 1);
      cycle("lw_x0");
      set_instr(1, 5'd0, 1, 5'd0, 1, 5'd9, 0, 1);
      cycle("x0_reader");

      // ex_stall for three cycles, then flush during stall.
      set_instr(1, 5'd1, 1, 5'd2, 1, 5'd10, 0, 1);
      id_rd2 = 32'hAAAAAAAA;
      cycle("pre_stall");
      held_rd2 = ex_rd2;
      held_pc  = ex_pc;
      ex_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_instr(1, 5'($urandom_range(0, 31)), 1, 5'd0, 0, 5'd11, 0, 1);
         cycle("stall");
         chk("stall/rd2_const", ex_rd2, 32'hAAAAAAAA);
         chk("stall/pc_held", ex_pc, held_pc);
      end
      flush = 1'b1;
      cycle("flush_in_stall");
      flush = 1'b0; ex_stall = 1'b0;
      cycle("after_flush");

      // Drive the bubble counter into saturation, then one more bubble.
      set_instr(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1);
      cycle("sat_seed");
      set_instr(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1);
      for (int i = 0; i < 100 && m_cnt != SAT; i++) begin
         cycle("sat_bubble");
         cycle("sat_capture");
      end
      cycle("sat_extra_bubble");
      chk("sat/held_at_max", 32'(load_use_cnt), 32'(SAT));

      // Reset between edges while EX holds a valid instruction.
      set_instr(1, 5'd1, 1, 5'd2, 1, 5'd12, 1, 1);
      cycle("pre_reset");
      #2;
      async_reset("mid_reset");
      set_instr(1, 5'd3, 1, 5'd4, 1, 5'd13, 0, 1);
      cycle("post_reset_capture");

      // Reset in the middle of a stall discards held contents.
      ex_stall = 1'b1;
      cycle("stall_pre_reset");
      #2;
      async_reset("reset_in_stall");
      ex_stall = 1'b0;
      set_instr(1, 5'd1, 1, 5'd1, 0, 5'd14, 0, 1);
      cycle("post_stall_reset");

      // Random traffic: small register index space to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         set_instr(1'($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
         flush    = ($urandom_range(0, 9) == 0);
         ex_stall = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 49) == 0) begin
            async_reset("rand_reset");
         end
         cycle("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
